// File: rtl/cum_thresh_finder_pkg.sv
// Shared constants and FSM encoding for the cumulative-histogram threshold finder.
// The reset threshold sits mid-scale so the thresholder has a sane value before the first frame.
package cum_thresh_finder_pkg;

    localparam int BINS   = 256;
    localparam int CNT_W  = 20;
    localparam int ADDR_W = 8;
    localparam int FRAC_W = 8;

    localparam logic [ADDR_W-1:0] RESET_THRESH = 8'd128;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ADDR,
        WAIT,
        CMP,
        DONE
    } state_t;

endpackage

// File: rtl/cum_thresh_finder.sv
// Binary search over an external cumulative-histogram RAM for the smallest gray
// level whose cumulative count reaches a fraction of the frame's pixel total.
module cum_thresh_finder
    import cum_thresh_finder_pkg::*;
#(
    parameter int BINS  = cum_thresh_finder_pkg::BINS,
    parameter int CNT_W = cum_thresh_finder_pkg::CNT_W
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic [CNT_W-1:0]  iTotal,
    input  logic [FRAC_W-1:0] iFraction,
    output logic [ADDR_W-1:0] oRdAddr,
    output logic              oRdEn,
    input  logic [CNT_W-1:0]  iRdData,
    output logic [ADDR_W-1:0] oThresh,
    output logic              oThreshValid,
    output logic              oBusy
);

    state_t state, state_nxt;

    logic [CNT_W-1:0]        total_q;
    logic [FRAC_W-1:0]       frac_q;
    logic [CNT_W-1:0]        target_q;
    logic [ADDR_W-1:0]       lo_q, hi_q, mid_q;
    logic [ADDR_W-1:0]       thresh_q;

    logic [CNT_W+FRAC_W-1:0] product;
    logic [CNT_W-1:0]        target_d;
    logic [ADDR_W-1:0]       mid;
    logic [ADDR_W-1:0]       lo_nxt, hi_nxt;
    logic                    hit;

    assign product  = {{FRAC_W{1'b0}}, total_q} * {{CNT_W{1'b0}}, frac_q};
    assign target_d = CNT_W'(product >> FRAC_W);

    // Written as lo + (hi-lo)/2 so the sum never needs a carry bit.
    assign mid    = lo_q + ((hi_q - lo_q) >> 1);
    assign hit    = (iRdData >= target_q);
    assign lo_nxt = hit ? lo_q  : mid_q + 1'b1;
    assign hi_nxt = hit ? mid_q : hi_q;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        oRdEn     = 1'b0;
        oRdAddr   = '0;
        case (state)
            IDLE: begin
                if (iStart) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                state_nxt = ADDR;
            end
            ADDR: begin
                oRdEn     = 1'b1;
                oRdAddr   = mid;
                state_nxt = WAIT;
            end
            WAIT: begin
                oRdAddr   = mid_q;
                state_nxt = CMP;
            end
            CMP: begin
                oRdAddr   = mid_q;
                state_nxt = (lo_nxt == hi_nxt) ? DONE : ADDR;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The result is loaded on the final compare so it is already visible in DONE.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            total_q  <= '0;
            frac_q   <= '0;
            target_q <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            mid_q    <= '0;
            thresh_q <= RESET_THRESH;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        total_q <= iTotal;
                        frac_q  <= iFraction;
                    end
                end
                CALC: begin
                    target_q <= target_d;
                    lo_q     <= '0;
                    hi_q     <= ADDR_W'(BINS - 1);
                end
                ADDR: begin
                    mid_q <= mid;
                end
                CMP: begin
                    lo_q <= lo_nxt;
                    hi_q <= hi_nxt;
                    if (lo_nxt == hi_nxt) begin
                        thresh_q <= lo_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign oThresh      = thresh_q;
    assign oThreshValid = (state == DONE);
    assign oBusy        = (state != IDLE);

endmodule

// File: tb/tb_cum_thresh_finder.sv
// Scoreboard bench: the reference scans the cumulative table for the first bin reaching the target,
// and a negedge monitor checks every cycle's busy/valid/read activity against the expected search windows.
module tb_cum_thresh_finder;

    localparam int CW = 20;

    logic          iClk = 1'b0;
    logic          iRst;
    logic          iStart;
    logic [CW-1:0] iTotal;
    logic [7:0]    iFraction;
    logic [7:0]    oRdAddr;
    logic          oRdEn;
    logic [CW-1:0] iRdData;
    logic [7:0]    oThresh;
    logic          oThreshValid;
    logic          oBusy;

    cum_thresh_finder #(.BINS(256), .CNT_W(CW)) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iStart       (iStart),
        .iTotal       (iTotal),
        .iFraction    (iFraction),
        .oRdAddr      (oRdAddr),
        .oRdEn        (oRdEn),
        .iRdData      (iRdData),
        .oThresh      (oThresh),
        .oThreshValid (oThreshValid),
        .oBusy        (oBusy)
    );

    always #5 iClk = ~iClk;

    logic [CW-1:0] cum [256];
    logic [CW-1:0] ram_q = '0;
    always @(posedge iClk) if (oRdEn) ram_q <= cum[oRdAddr];
    assign iRdData = ram_q;

    typedef struct {
        int thresh;
        int cyc;
    } exp_t;
    exp_t sb[$];

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int act_start = -1000;
    int act_end = -1000;
    int rd_cnt = 0;
    int last_thresh = -1;
    bit mon_en = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int refThresh(input int total, input int frac);
        longint t;
        t = ((longint'(total) * longint'(frac)) >> 8) & 64'hFFFFF;
        for (int a = 0; a < 256; a++) begin
            if (longint'(cum[a]) >= t) return a;
        end
        return 255;
    endfunction

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    function automatic bit modelBusy(input int c);
        return (c >= act_start + 1) && (c <= act_end);
    endfunction

    task automatic applyStimulus(input int total, input int frac, input bit withRst);
        int c;
        c = cyc;
        iStart    = 1'b1;
        iTotal    = CW'(total);
        iFraction = 8'(frac);
        iRst      = withRst;
        if (!modelBusy(c) && !withRst) begin
            act_start = c;
            act_end   = c + 26;
            sb.push_back('{refThresh(total, frac), c + 26});
        end
        tick();
        iStart    = 1'b0;
        iRst      = 1'b0;
        iTotal    = CW'($urandom);
        iFraction = 8'($urandom);
    endtask

    task automatic applyReset();
        int c;
        c = cyc;
        if (modelBusy(c)) begin
            if (c < act_start + 26) sb.delete();
            act_end = c;
        end
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        checkOutput("rst_thresh", 32'(oThresh), 128);
        checkOutput("rst_busy", 32'(oBusy), 0);
        checkOutput("rst_valid", 32'(oThreshValid), 0);
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (cyc <= act_end && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) checkOutput("idle_timeout", 1, 0);
        tick();
    endtask

    task automatic loadRamp();
        for (int a = 0; a < 256; a++) cum[a] = CW'((a + 1) * 1500);
    endtask

    task automatic loadConst(input int v, input int last);
        for (int a = 0; a < 255; a++) cum[a] = CW'(v);
        cum[255] = CW'(last);
    endtask

    task automatic loadRandom(input bit sparse);
        int acc;
        acc = 0;
        for (int a = 0; a < 256; a++) begin
            if (!sparse || $urandom_range(0, 3) == 0) acc += $urandom_range(0, 4000);
            cum[a] = CW'(acc);
        end
    endtask

    // Every cycle the monitor knows from the model whether a search should be in flight.
    always @(negedge iClk) begin : monitor
        bit   expBusy;
        bit   expValid;
        exp_t e;
        if (mon_en) begin
            expBusy  = modelBusy(cyc);
            expValid = (cyc == act_start + 26) && (act_end == act_start + 26);
            if (cyc == act_start) rd_cnt = 0;
            checkOutput("busy", 32'(oBusy), 32'(expBusy));
            checkOutput("valid", 32'(oThreshValid), 32'(expValid));
            if (!expBusy) begin
                checkOutput("idle_rden", 32'(oRdEn), 0);
                checkOutput("idle_addr", 32'(oRdAddr), 0);
            end
            if (oRdEn === 1'b1) rd_cnt++;
            if (oThreshValid === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    last_thresh = int'(oThresh);
                    checkOutput("thresh", 32'(oThresh), 32'(e.thresh));
                    checkOutput("latency", 32'(cyc), 32'(e.cyc));
                    checkOutput("rden_pulses", 32'(rd_cnt), 8);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        iRst      = 1'b1;
        iStart    = 1'b0;
        iTotal    = '0;
        iFraction = '0;
        loadConst(0, 0);
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1'b0;
        checkOutput("reset_thresh", 32'(oThresh), 128);
        checkOutput("reset_valid", 32'(oThreshValid), 0);
        checkOutput("reset_busy", 32'(oBusy), 0);
        checkOutput("reset_rden", 32'(oRdEn), 0);
        checkOutput("reset_addr", 32'(oRdAddr), 0);
        mon_en = 1'b1;
        tick();

        $display("[TB] linear ramp, half fraction");
        loadRamp();
        applyStimulus(384000, 128, 1'b0);
        waitIdle();
        checkOutput("ramp_thresh", 32'(last_thresh), 127);

        $display("[TB] all pixels at gray 255");
        loadConst(0, 384000);
        applyStimulus(384000, 128, 1'b0);
        waitIdle();
        checkOutput("gray255_thresh", 32'(last_thresh), 255);

        $display("[TB] all pixels at gray 0");
        loadConst(384000, 384000);
        applyStimulus(384000, 255, 1'b0);
        waitIdle();
        checkOutput("gray0_thresh", 32'(last_thresh), 0);
        last_thresh = -1;
        applyStimulus(384000, 0, 1'b0);
        waitIdle();
        checkOutput("frac0_thresh", 32'(last_thresh), 0);

        $display("[TB] target above every bin");
        loadConst(0, 0);
        applyStimulus(384000, 200, 1'b0);
        waitIdle();
        checkOutput("empty_thresh", 32'(last_thresh), 255);

        $display("[TB] second start mid-search and in DONE");
        loadRamp();
        applyStimulus(384000, 128, 1'b0);
        repeat (9) tick();
        applyStimulus(384000, 64, 1'b0);
        repeat (15) tick();
        applyStimulus(384000, 32, 1'b0);
        waitIdle();

        $display("[TB] reset mid-search then restart");
        applyStimulus(384000, 128, 1'b0);
        repeat (14) tick();
        applyReset();
        tick();
        applyStimulus(384000, 200, 1'b0);
        waitIdle();

        $display("[TB] start coincident with reset");
        applyStimulus(384000, 128, 1'b1);
        repeat (3) tick();

        $display("[TB] randomized frames");
        for (int b = 0; b < 6; b++) begin
            waitIdle();
            loadRandom(b[0]);
            for (int k = 0; k < 6; k++) begin
                repeat ($urandom_range(0, 35)) tick();
                if ($urandom_range(0, 2) == 0)
                    applyStimulus(int'($urandom_range(0, 20'hFFFFF)), int'($urandom_range(0, 255)), 1'b0);
                else
                    applyStimulus(int'(cum[255]), int'($urandom_range(0, 255)), 1'b0);
            end
        end
        waitIdle();
        repeat (3) tick();
        checkOutput("sb_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cum_thresh_finder.md
CUM_THRESH_FINDER -- requirements
Module: cum_thresh_finder

Interface
REQ-001 The block SHALL have the parameter BINS, default 256, meaning the number of histogram bins; it is fixed to a power of two.
REQ-002 The block SHALL have the parameter CNT_W, default 20, meaning the cumulative-count width.
REQ-003 The block SHALL have port iClk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port iRst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port iStart, input, 1 bit: single-cycle pulse at frame end, when the cumulative histogram RAM is complete.
REQ-006 The block SHALL have port iTotal, input, CNT_W bits: total pixel count of the frame.
REQ-007 The block SHALL have port iFraction, input, 8 bits: unsigned Q0.8 target fraction of iTotal.
REQ-008 The block SHALL have port oRdAddr, output, 8 bits: read address to the cumulative histogram RAM.
REQ-009 The block SHALL have port oRdEn, output, 1 bit: read enable to the cumulative histogram RAM.
REQ-010 The block SHALL have port iRdData, input, CNT_W bits: RAM read data, valid exactly 1 cycle after oRdAddr/oRdEn.
REQ-011 The block SHALL have port oThresh, output, 8 bits: threshold gray level fed to the thresholder; holds its value between updates.
REQ-012 The block SHALL have port oThreshValid, output, 1 bit: one-cycle pulse when oThresh updates.
REQ-013 The block SHALL have port oBusy, output, 1 bit: high from the cycle after iStart is accepted until the DONE cycle, inclusive.

Function
REQ-014 The block SHALL compute oThresh as the smallest address a with cum[a] >= target; if no such a exists, oThresh SHALL be 255.
REQ-015 target SHALL be (iTotal * iFraction) >> 8: 28-bit unsigned product, truncated to CNT_W bits, compared unsigned.
REQ-016 iTotal and iFraction SHALL be sampled only on the cycle iStart is accepted.
REQ-017 The FSM SHALL have the states IDLE, CALC, ADDR, WAIT, CMP and DONE.
REQ-018 In IDLE, iStart SHALL be accepted, the inputs latched, and the FSM SHALL go to CALC.
REQ-019 In CALC, target SHALL be registered, lo=0 and hi=BINS-1 set, and the FSM SHALL go to ADDR.
REQ-020 In ADDR, oRdAddr SHALL be driven to mid=(lo+hi)>>1 and oRdEn=1, and the FSM SHALL go to WAIT.
REQ-021 In WAIT, oRdAddr SHALL be held and oRdEn=0, and the FSM SHALL go to CMP.
REQ-022 In CMP, if iRdData >= target then hi=mid, else lo=mid+1; the FSM SHALL go to DONE when the new lo==hi, else to ADDR.
REQ-023 In DONE, oThresh SHALL be set to lo, oThreshValid=1 for this cycle only, and the FSM SHALL go to IDLE.
REQ-024 For BINS=256 the search SHALL always run exactly 8 iterations, each of 3 cycles.
REQ-025 Latency SHALL be fixed: with iStart sampled at cycle 0, CALC is cycle 1, iterations occupy cycles 2-25, and DONE with oThreshValid=1 is cycle 26.
REQ-026 An iStart arriving while oBusy=1 SHALL be ignored, not queued; an iStart in the DONE cycle SHALL also be ignored.
REQ-027 iRdData SHALL be sampled only in CMP; its value in other states has no effect.
REQ-028 When target=0 (including iFraction=0 or iTotal=0), the result SHALL be 0.
REQ-029 oRdAddr SHALL be 0 and oRdEn 0 whenever the FSM is in IDLE.

Reset
REQ-030 On iRst=1 the FSM SHALL enter IDLE with oThresh=8'd128, oThreshValid=0, oBusy=0, oRdEn=0 and oRdAddr=0.
REQ-031 A reset during a search SHALL abort it; no oThreshValid pulse SHALL follow, and oThresh SHALL read 128 from the next cycle.
REQ-032 iStart coincident with iRst=1 SHALL be ignored.

Structure
REQ-033 The shared package SHALL hold BINS, CNT_W, ADDR_W=8, FRAC_W=8, the FSM state encoding and the reset threshold constant 128.
REQ-034 The block SHALL be a single module with no sub-module; the multiplier is inline, and the RAM is external and shared with the cumulative histogram builder.

Verification
REQ-035 Linear ramp cum[a]=(a+1)*1500, iTotal=384000, iFraction=128 -> target=192000, oThresh=127, oThreshValid exactly 26 cycles after iStart.
REQ-036 All pixels at gray 255 (cum[a]=0 for a<255, cum[255]=384000), iFraction=128 -> oThresh=255.
REQ-037 All pixels at gray 0 (cum[a]=384000 for all a), iFraction=255 -> target=382500, oThresh=0; iFraction=0 -> oThresh=0.
REQ-038 cum[a]=0 for all a with iTotal=384000 (target exceeds every bin), iFraction=200 -> oThresh=255.
REQ-039 Second iStart at cycle 10 of a search -> ignored, exactly one oThreshValid at cycle 26, and oRdEn pulses exactly 8 times.
REQ-040 iRst asserted at cycle 15 of a search -> no oThreshValid, oThresh=128, oBusy=0 next cycle; a new iStart then completes normally in 26 cycles.
